// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit pattern LFSR (x^4+x^3+1, period 15).
// Both the generator and the checker use this package, so both sides
// step the same sequence.
package lfsr_pkg;

    localparam int              LFSR_W     = 4;
    localparam logic [LFSR_W-1:0] RESET_SEED = 4'hF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // One LFSR step: shift left and feed back s[3]^s[2] into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR pattern checker. It seeds its prediction from the
// incoming stream, locks after LOCK_CNT correct predictions, and then
// free-runs its own prediction. While locked it flags and counts
// mismatches, and it drops lock after UNLOCK_CNT consecutive misses.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [LFSR_W-1:0]    data_i,
    input  logic                 valid_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 zero_o
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [MATCH_W-1:0]   LOCK_TGT   = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]    UNLOCK_TGT = MISS_W'(UNLOCK_CNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    state_e                 state_q, state_d;
    logic [LFSR_W-1:0]      expected_q, expected_d;
    logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]      miss_cnt_q, miss_cnt_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic                   zero_q, zero_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [MATCH_W-1:0]     match_inc;
    logic [MISS_W-1:0]      miss_inc;
    logic                   err_hit;

    // Next-state, prediction, counters and output pulses.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        zero_d      = 1'b0;
        err_hit     = 1'b0;
        match_inc   = match_cnt_q + 1'b1;
        miss_inc    = miss_cnt_q + 1'b1;

        if (valid_i) begin
            case (state_q)
                SEARCH: begin
                    if (data_i != '0) begin
                        expected_d  = lfsr_next(data_i);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
                VERIFY: begin
                    if (data_i == '0) begin
                        // All-zero is the LFSR lockup word; never a valid seed.
                        zero_d  = 1'b1;
                        state_d = SEARCH;
                    end else if (data_i == expected_q) begin
                        expected_d  = lfsr_next(data_i);
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_TGT) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        // Reseed from the word just seen and start counting again.
                        expected_d  = lfsr_next(data_i);
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running prediction so a lone bit error does not propagate.
                    expected_d = lfsr_next(expected_q);
                    if (data_i == expected_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_hit    = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == UNLOCK_TGT) begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        // Clear wins over a same-cycle error increment; the count saturates.
        err_cnt_d = err_cnt_q;
        if (clear_i) begin
            err_cnt_d = '0;
        end else if (err_hit && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        locked_d = (state_d == LOCKED);
    end

    // State, prediction and registered outputs; reset abandons lock at once.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= SEARCH;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            zero_q      <= zero_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign zero_o    = zero_q;
    assign err_cnt_o = err_cnt_q;

endmodule
